mbist_repair_cam: RTL and testbench

MBIST_REPAIR_CAM -- requirements
Module: mbist_repair_cam

---
 rtl/mbist_repair_cam.sv | 129 ++++++++++++
 tb/tb_mbist_repair_cam.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mbist_repair_cam.sv
`default_nettype none
// ============================================================================
// Module      : mbist_repair_cam
// Description : BIST-driven spare-row repair CAM with combinational address
//               remap and a scannable repair chain.
// Revision    : 1.0  initial release
// ============================================================================
module mbist_repair_cam #(
    parameter int ADDR_WD           = 9,
    parameter int NUM_REPAIR        = 4,
    parameter int REPAIR_ADDR_START = 'h1FC
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              error,
    input  logic [ADDR_WD-1:0]                error_addr,
    input  logic [ADDR_WD-1:0]                addr_in,
    output logic [ADDR_WD-1:0]                addr_out,
    output logic                              hit,
    output logic                              correct,
    output logic                              repair_fail,
    output logic [$clog2(NUM_REPAIR+1)-1:0]   repair_cnt,
    input  logic                              scan_shift,
    input  logic                              sdi,
    output logic                              sdo
);

    localparam int               c_ew    = ADDR_WD + 1;
    localparam int               c_len   = NUM_REPAIR * c_ew;
    localparam int               c_cw    = $clog2(NUM_REPAIR + 1);
    localparam logic [ADDR_WD:0] c_start = (ADDR_WD + 1)'(REPAIR_ADDR_START);

    generate
        if ((REPAIR_ADDR_START + NUM_REPAIR > 2 ** ADDR_WD) ||
            (NUM_REPAIR < 1) || (NUM_REPAIR > 16)) begin : g_bad_params
            $error("mbist_repair_cam: spare rows do not fit the address space");
        end
    endgenerate

    // Entry i occupies chain bits [i*c_ew +: c_ew] as {valid, addr}.
    logic [c_len-1:0]      r_chain;
    logic                  r_fail;

    logic [NUM_REPAIR-1:0] w_valid;
    logic [ADDR_WD-1:0]    w_addr [NUM_REPAIR];
    logic [NUM_REPAIR-1:0] w_alloc;
    logic                  w_free;
    logic                  w_dup;
    logic                  w_spare_region;
    logic [ADDR_WD-1:0]    w_addr_out;
    logic                  w_hit;
    logic [c_cw-1:0]       w_cnt;

    generate
        for (genvar gi = 0; gi < NUM_REPAIR; gi++) begin : g_entry
            assign w_valid[gi] = r_chain[gi*c_ew + ADDR_WD];
            assign w_addr[gi]  = r_chain[gi*c_ew +: ADDR_WD];
        end
    endgenerate

    assign w_spare_region = ({1'b0, error_addr} >= c_start);

    always_comb begin
        w_alloc = '0;
        w_free  = 1'b0;
        w_dup   = 1'b0;
        for (int i = 0; i < NUM_REPAIR; i++) begin
            if (w_valid[i] && (w_addr[i] == error_addr)) begin
                w_dup = 1'b1;
            end
            if (!w_valid[i] && !w_free) begin
                w_alloc[i] = 1'b1;
                w_free     = 1'b1;
            end
        end
    end

    // Walk downward so the lowest matching index takes precedence.
    always_comb begin
        w_addr_out = addr_in;
        w_hit      = 1'b0;
        for (int i = NUM_REPAIR - 1; i >= 0; i--) begin
            if (w_valid[i] && (w_addr[i] == addr_in)) begin
                w_addr_out = ADDR_WD'(REPAIR_ADDR_START + i);
                w_hit      = 1'b1;
            end
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NUM_REPAIR; i++) begin
            w_cnt = w_cnt + c_cw'(w_valid[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_chain <= '0;
            r_fail  <= 1'b0;
        end else if (scan_shift) begin
            r_chain <= {sdi, r_chain[c_len-1:1]};
        end else if (error) begin
            if (w_spare_region) begin
                r_fail <= 1'b1;
            end else if (!w_dup) begin
                if (w_free) begin
                    for (int i = 0; i < NUM_REPAIR; i++) begin
                        if (w_alloc[i]) begin
                            r_chain[i*c_ew +: c_ew] <= {1'b1, error_addr};
                        end
                    end
                end else begin
                    r_fail <= 1'b1;
                end
            end
        end
    end

    assign addr_out    = w_addr_out;
    assign hit         = w_hit;
    assign repair_cnt  = w_cnt;
    assign correct     = (w_cnt != '0);
    assign repair_fail = r_fail;
    assign sdo         = r_chain[0];

endmodule
`default_nettype wire

// File: tb/tb_mbist_repair_cam.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbist_repair_cam
// Description : Directed and randomized checks of mbist_repair_cam against an
//               entry-table reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mbist_repair_cam;

    localparam int          AW    = 9;
    localparam int          N     = 4;
    localparam int          L     = N * (AW + 1);
    localparam logic [8:0]  START = 9'h1FC;

    logic       clk = 1'b0;
    logic       rst, clear, error, scan_shift, sdi;
    logic [8:0] error_addr, addr_in;
    logic [8:0] addr_out;
    logic       hit, correct, repair_fail, sdo;
    logic [2:0] repair_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    bit         m_v [N];
    logic [8:0] m_a [N];
    bit         m_fail;

    mbist_repair_cam dut (
        .clk(clk), .rst(rst), .clear(clear), .error(error),
        .error_addr(error_addr), .addr_in(addr_in), .addr_out(addr_out),
        .hit(hit), .correct(correct), .repair_fail(repair_fail),
        .repair_cnt(repair_cnt), .scan_shift(scan_shift), .sdi(sdi), .sdo(sdo)
    );

    always #5 clk = ~clk;

    // Reference: a table of spare rows updated by the documented priority rules.
    function automatic void model_edge();
        bit chain [L];
        bit found;
        if (rst || clear) begin
            for (int i = 0; i < N; i++) begin m_v[i] = 0; m_a[i] = '0; end
            m_fail = 0;
        end else if (scan_shift) begin
            for (int i = 0; i < N; i++) begin
                for (int b = 0; b < AW; b++) chain[i*(AW+1)+b] = m_a[i][b];
                chain[i*(AW+1)+AW] = m_v[i];
            end
            for (int k = 0; k < L-1; k++) chain[k] = chain[k+1];
            chain[L-1] = sdi;
            for (int i = 0; i < N; i++) begin
                for (int b = 0; b < AW; b++) m_a[i][b] = chain[i*(AW+1)+b];
                m_v[i] = chain[i*(AW+1)+AW];
            end
        end else if (error) begin
            found = 0;
            for (int i = 0; i < N; i++) if (m_v[i] && m_a[i] == error_addr) found = 1;
            if (error_addr >= START) m_fail = 1;
            else if (!found) begin
                for (int i = 0; i < N; i++) begin
                    if (!found && !m_v[i]) begin m_v[i] = 1; m_a[i] = error_addr; found = 1; end
                end
                if (!found) m_fail = 1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit r, input bit c, input bit s, input bit d,
                         input bit e, input logic [8:0] ea);
        rst = r; clear = c; scan_shift = s; sdi = d; error = e; error_addr = ea;
        tick();
        rst = 0; clear = 0; scan_shift = 0; error = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [8:0] e_out;
        bit         e_hit;
        int         e_cnt;
        #1;
        e_out = addr_in; e_hit = 0; e_cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (m_v[i]) e_cnt++;
            if (!e_hit && m_v[i] && m_a[i] == addr_in) begin
                e_out = START + 9'(i); e_hit = 1;
            end
        end
        chk({tag, ".addr_out"},    32'(addr_out),    32'(e_out));
        chk({tag, ".hit"},         32'(hit),         32'(e_hit));
        chk({tag, ".repair_cnt"},  32'(repair_cnt),  32'(e_cnt));
        chk({tag, ".correct"},     32'(correct),     32'(e_cnt != 0));
        chk({tag, ".repair_fail"}, 32'(repair_fail), 32'(m_fail));
        chk({tag, ".sdo"},         32'(sdo),         32'(m_a[0][0]));
    endtask

    logic [L-1:0] want;

    initial begin
        rst = 1; clear = 0; error = 0; scan_shift = 0; sdi = 0;
        error_addr = '0; addr_in = 9'h010;
        m_fail = 0;
        for (int i = 0; i < N; i++) begin m_v[i] = 0; m_a[i] = '0; end

        drive(1, 0, 0, 0, 0, '0);
        check_all("reset");
        chk("reset.passthru", 32'(addr_out), 32'h010);

        // First allocation; remap must not change during the error cycle.
        error = 1; error_addr = 9'h010; #1;
        chk("alloc.same_cycle_hit", 32'(hit), 32'h0);
        tick(); error = 0;
        check_all("alloc");
        chk("alloc.remap", 32'(addr_out), 32'h1FC);
        chk("alloc.cnt",   32'(repair_cnt), 32'd1);

        drive(1, 0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 1, 9'h010);
        drive(0, 0, 0, 0, 1, 9'h010);
        drive(0, 0, 0, 0, 1, 9'h020);
        addr_in = 9'h020;
        check_all("dup");
        chk("dup.remap", 32'(addr_out), 32'h1FD);
        chk("dup.cnt",   32'(repair_cnt), 32'd2);
        chk("dup.fail",  32'(repair_fail), 32'd0);

        drive(1, 0, 0, 0, 0, '0);
        for (int k = 1; k <= 5; k++) drive(0, 0, 0, 0, 1, 9'(k));
        addr_in = 9'h005;
        check_all("overflow");
        chk("overflow.fail",  32'(repair_fail), 32'd1);
        chk("overflow.nohit", 32'(addr_out), 32'h005);
        addr_in = 9'h004;
        check_all("overflow4");
        chk("overflow4.remap", 32'(addr_out), 32'h1FF);
        drive(0, 1, 0, 0, 1, 9'h006);
        check_all("clear");
        chk("clear.fail", 32'(repair_fail), 32'd0);
        chk("clear.cnt",  32'(repair_cnt), 32'd0);

        drive(0, 0, 0, 0, 1, 9'h1FD);
        check_all("spare");
        chk("spare.fail", 32'(repair_fail), 32'd1);
        chk("spare.cnt",  32'(repair_cnt), 32'd0);
        drive(0, 1, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 1, 9'h1FB);
        addr_in = 9'h1FB;
        check_all("edge_1fb");
        chk("edge_1fb.remap", 32'(addr_out), 32'h1FC);
        drive(0, 0, 0, 0, 1, 9'h1FC);
        check_all("edge_1fc");
        chk("edge_1fc.fail", 32'(repair_fail), 32'd1);

        // Loopback scan leaves the table intact; an error mid-shift is dropped.
        drive(1, 0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 1, 9'h030);
        drive(0, 0, 0, 0, 1, 9'h040);
        for (int k = 0; k < L; k++) begin
            drive(0, 0, 1, sdo, (k == 7), 9'h050);
            chk("loop.sdo", 32'(sdo), 32'(m_a[0][0]));
        end
        addr_in = 9'h040;
        check_all("loop");
        chk("loop.remap", 32'(addr_out), 32'h1FD);
        chk("loop.cnt",   32'(repair_cnt), 32'd2);
        addr_in = 9'h050;
        check_all("loop_err");
        chk("loop_err.nohit", 32'(hit), 32'd0);

        // Scan-load duplicate entries 1 and 2; the lower index must win.
        want = {10'h0, 1'b1, 9'h077, 1'b1, 9'h077, 10'h0};
        for (int k = 0; k < L; k++) drive(0, 0, 1, want[k], 0, '0);
        addr_in = 9'h077;
        check_all("scanload");
        chk("scanload.remap", 32'(addr_out), 32'h1FD);

        drive(1, 0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 1, 9'h060);
        addr_in = 9'h060;
        drive(1, 0, 0, 0, 0, '0);
        check_all("rst_after_alloc");
        chk("rst_after_alloc.hit", 32'(hit), 32'd0);
        drive(0, 0, 0, 0, 1, 9'h061);
        for (int k = 0; k < 5; k++) drive(0, 0, 1, 1'b1, 0, '0);
        drive(1, 0, 1, 1'b1, 1, 9'h062);
        check_all("rst_mid_shift");
        chk("rst_mid_shift.cnt", 32'(repair_cnt), 32'd0);

        for (int k = 0; k < 400; k++) begin
            logic [8:0] ea;
            ea = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 7))
                                            : 9'($urandom_range(9'h1F8, 9'h1FF));
            addr_in = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 7))
                                                 : 9'($urandom_range(9'h1F8, 9'h1FF));
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), ea);
            check_all("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
